// File: rtl/pic_pkg.sv
// Shared PIC core definitions: program memory geometry, loader frame sync byte
// and the loader FSM state encoding. Used by the loader, program counter and ROM.
package pic_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned OP_W   = 14;

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CKSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Byte-serial program loader: parses SYNC/ADDR/LEN/DATA/CKSUM frames from a
// valid/ready byte stream and writes 14-bit opcodes into program memory.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   prog_en           loader enable; low aborts the current frame
//   in_valid/in_data  offered byte; in_ready accepts it (combinational)
//   wr_en/wr_addr/wr_data  one-cycle program memory write
//   core_hold         holds the core in reset while a frame is active
//   done/error        sticky frame status, cleared by the next SYNC
module prog_loader
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_en,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OP_W-1:0]   wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [OP_W-1:0]   data_q, data_nxt;
  logic [5:0]        hi_q, hi_nxt;
  logic [7:0]        cnt_q, cnt_nxt;
  logic [7:0]        sum_q, sum_nxt;
  logic              wr_en_q, wr_en_nxt;
  logic              hold_q, hold_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic              accept;
  logic [7:0]        sum_add;

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign in_ready = reset && prog_en &&
                    (state != ST_WRITE) && (state != ST_DONE) && (state != ST_ERR);
  assign accept   = in_valid && in_ready;
  assign sum_add  = 8'(sum_q + in_data);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      wr_en_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      hi_q    <= hi_nxt;
      cnt_q   <= cnt_nxt;
      sum_q   <= sum_nxt;
      wr_en_q <= wr_en_nxt;
      hold_q  <= hold_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    hi_nxt    = hi_q;
    cnt_nxt   = cnt_q;
    sum_nxt   = sum_q;
    wr_en_nxt = 1'b0;
    hold_nxt  = hold_q;
    done_nxt  = done_q;
    err_nxt   = err_q;

    if (!prog_en) begin
      state_nxt = ST_IDLE;
      hold_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (in_data == SYNC)) begin
            state_nxt = ST_ADDR_HI;
            sum_nxt   = '0;
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
            hold_nxt  = 1'b1;
          end
        end
        ST_ADDR_HI: begin
          if (accept) begin
            addr_nxt  = {in_data[2:0], addr_q[7:0]};
            sum_nxt   = sum_add;
            state_nxt = ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (accept) begin
            addr_nxt  = {addr_q[ADDR_W-1:8], in_data};
            sum_nxt   = sum_add;
            state_nxt = ST_LEN;
          end
        end
        ST_LEN: begin
          if (accept) begin
            cnt_nxt   = in_data;
            sum_nxt   = sum_add;
            state_nxt = (in_data == 8'd0) ? ST_CKSUM : ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          if (accept) begin
            sum_nxt = sum_add;
            // Opcodes are only 14 bits; set top bits mean a malformed frame.
            if (in_data[7:6] != 2'b00) begin
              state_nxt = ST_ERR;
              err_nxt   = 1'b1;
              hold_nxt  = 1'b0;
            end else begin
              hi_nxt    = in_data[5:0];
              state_nxt = ST_DATA_LO;
            end
          end
        end
        ST_DATA_LO: begin
          if (accept) begin
            data_nxt  = {hi_q, in_data};
            wr_en_nxt = 1'b1;
            cnt_nxt   = 8'(cnt_q - 8'd1);
            sum_nxt   = sum_add;
            state_nxt = ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Address advances after the strobe cycle; wraps at the top of memory.
          addr_nxt  = ADDR_W'(addr_q + ADDR_W'(1));
          state_nxt = (cnt_q == 8'd0) ? ST_CKSUM : ST_DATA_HI;
        end
        ST_CKSUM: begin
          if (accept) begin
            sum_nxt  = sum_add;
            hold_nxt = 1'b0;
            if (sum_add == 8'd0) begin
              state_nxt = ST_DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ST_ERR;
              err_nxt   = 1'b1;
            end
          end
        end
        ST_DONE:  state_nxt = ST_IDLE;
        ST_ERR:   state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign core_hold = hold_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven frames, hand-written
// abort/reset sequences and random frames with random valid gaps, all checked
// against a frame-parsing reference model.
module tb_prog_loader;
  import pic_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              prog_en;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [OP_W-1:0]   wr_data;
  logic              core_hold;
  logic              done;
  logic              error;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .prog_en   (prog_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b [16];
    int         n;
    logic       exp_done;
    logic       exp_err;
    int         exp_nwr;
  } vec_t;

  vec_t       tbl [5];
  int         total = 0;
  int         bad = 0;
  logic [7:0] frm [$];
  int         exp_addr [$];
  int         exp_data [$];
  int         got_addr [$];
  int         got_data [$];
  int         sav_addr [$];
  int         sav_data [$];
  int         ovl;
  bit         exp_done, exp_err;

  // Write monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(int'(wr_data));
      if (in_ready) ovl++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 40) begin
        chk("ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference model: parses the frame directly from its byte layout.
  task automatic model();
    int a, len, idx, sum, hi, lo;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    a   = (int'(frm[1]) % 8) * 256 + int'(frm[2]);
    len = int'(frm[3]);
    sum = int'(frm[1]) + int'(frm[2]) + int'(frm[3]);
    idx = 4;
    for (int w = 0; w < len; w++) begin
      hi = int'(frm[idx]);
      if (hi >= 64) begin
        exp_err = 1'b1;
        return;
      end
      lo = int'(frm[idx+1]);
      exp_addr.push_back(a);
      exp_data.push_back((hi % 64) * 256 + lo);
      a   = (a + 1) % 2048;
      sum = sum + hi + lo;
      idx = idx + 2;
    end
    sum      = sum + int'(frm[idx]);
    exp_done = ((sum % 256) == 0);
    exp_err  = !exp_done;
  endtask

  task automatic run_frame(input int gapmax);
    got_addr.delete();
    got_data.delete();
    ovl = 0;
    foreach (frm[i]) begin
      send_byte(frm[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      if (i == 0) chk("core_hold_after_sync", int'(core_hold), 1);
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string nm);
    chk({nm, "_nwr_model"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      chk({nm, "_addr"}, got_addr[i], exp_addr[i]);
      chk({nm, "_data"}, got_data[i], exp_data[i]);
    end
    chk({nm, "_done"}, int'(done), int'(exp_done));
    chk({nm, "_error"}, int'(error), int'(exp_err));
    chk({nm, "_ready_in_write"}, ovl, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, int'(in_ready), 0);
    chk({nm, "_wr_en"}, int'(wr_en), 0);
    chk({nm, "_wr_addr"}, int'(wr_addr), 0);
    chk({nm, "_wr_data"}, int'(wr_data), 0);
    chk({nm, "_core_hold"}, int'(core_hold), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_error"}, int'(error), 0);
  endtask

  initial begin
    tbl[0] = '{b: '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h30, 8'h0A, 8'h07, 8'h80, 8'h2D,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               n: 9, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 2};
    tbl[1] = '{b: '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h30, 8'h0A, 8'h07, 8'h80, 8'h2E,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               n: 9, exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 2};
    tbl[2] = '{b: '{8'hA5, 8'h07, 8'hFF, 8'h02, 8'h12, 8'h34, 8'h05, 8'h67, 8'h46,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               n: 9, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 2};
    tbl[3] = '{b: '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               n: 5, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 0};
    tbl[4] = '{b: '{8'hA5, 8'h00, 8'h20, 8'h02, 8'h12, 8'h34, 8'hC0, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               n: 7, exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 1};

    reset    = 1'b0;
    prog_en  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ovl      = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset   = 1'b1;
    prog_en = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames
    for (int t = 0; t < 5; t++) begin
      frm.delete();
      for (int j = 0; j < tbl[t].n; j++) frm.push_back(tbl[t].b[j]);
      model();
      run_frame(0);
      // One cycle after the last byte: DONE or ERR
      chk($sformatf("t%0d_hold_end", t), int'(core_hold), 0);
      chk($sformatf("t%0d_ready_end", t), int'(in_ready), 0);
      chk($sformatf("t%0d_done_end", t), int'(done), int'(tbl[t].exp_done));
      chk($sformatf("t%0d_error_end", t), int'(error), int'(tbl[t].exp_err));
      settle();
      chk($sformatf("t%0d_nwr", t), got_addr.size(), tbl[t].exp_nwr);
      cmp_model($sformatf("t%0d", t));
      if (t == 0 && got_addr.size() == 2) begin
        chk("t0_w0_addr", got_addr[0], 'h010);
        chk("t0_w0_data", got_data[0], 'h300A);
        chk("t0_w1_addr", got_addr[1], 'h011);
        chk("t0_w1_data", got_data[1], 'h0780);
        chk("t0_addr_after", int'(wr_addr), 'h012);
        chk("t0_data_hold", int'(wr_data), 'h0780);
      end
      if (t == 2 && got_addr.size() == 2) begin
        chk("wrap_w0_addr", got_addr[0], 'h7FF);
        chk("wrap_w1_addr", got_addr[1], 'h000);
      end
    end

    // Abort: drop prog_en right after the first DATA_LO is accepted.
    got_addr.delete();
    got_data.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    prog_en = 1'b0;
    @(negedge clk);
    chk("abort_ready_low", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("abort_hold_low", int'(core_hold), 0);
    chk("abort_ready_low2", int'(in_ready), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_error", int'(error), 0);
    repeat (3) @(posedge clk);
    #1;
    prog_en = 1'b1;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    settle();
    chk("abort_nwr", got_addr.size(), 1);
    if (got_addr.size() > 0) begin
      chk("abort_w0_addr", got_addr[0], 'h040);
      chk("abort_w0_data", got_data[0], 'h1122);
    end
    chk("abort_hold_idle", int'(core_hold), 0);

    // Asynchronous reset in the middle of a frame, just before its DATA_LO.
    got_addr.delete();
    got_data.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h50, 0);
    send_byte(8'h01, 0);
    send_byte(8'h05, 0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_nwr", got_addr.size(), 0);
    chk("midreset_hold_after", int'(core_hold), 0);
    chk("midreset_addr_after", int'(wr_addr), 0);

    // Random frames: gapless run, then the same frame with random valid gaps.
    for (int r = 0; r < 6; r++) begin
      int a, len, sum, hi, lo;
      a   = (r == 0) ? 2045 : int'($urandom_range(0, 2047));
      len = int'($urandom_range(1, 6));
      frm.delete();
      frm.push_back(8'hA5);
      frm.push_back(8'(a / 256));
      frm.push_back(8'(a % 256));
      frm.push_back(8'(len));
      sum = a / 256 + a % 256 + len;
      for (int w = 0; w < len; w++) begin
        hi = int'($urandom_range(0, 63));
        lo = int'($urandom_range(0, 255));
        frm.push_back(8'(hi));
        frm.push_back(8'(lo));
        sum = sum + hi + lo;
      end
      if (r == 3) frm.push_back(8'((256 - (sum % 256) + 1) % 256));
      else        frm.push_back(8'((256 - (sum % 256)) % 256));
      model();
      run_frame(0);
      settle();
      cmp_model($sformatf("r%0d_nogap", r));
      sav_addr = got_addr;
      sav_data = got_data;
      run_frame(4);
      settle();
      cmp_model($sformatf("r%0d_gap", r));
      chk($sformatf("r%0d_gap_vs_nogap_n", r), got_addr.size(), sav_addr.size());
      for (int i = 0; i < sav_addr.size() && i < got_addr.size(); i++) begin
        chk($sformatf("r%0d_gap_vs_nogap_addr", r), got_addr[i], sav_addr[i]);
        chk($sformatf("r%0d_gap_vs_nogap_data", r), got_data[i], sav_data[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
